// File: rtl/sqrt_pkg.sv
// Shared types and helpers for the square-root sequencer and its datapath.
package sqrt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ITER,
    CORR,
    DONE
  } sqrt_seq_state_e;

  // One root bit is resolved per iteration, so a DW-bit radicand needs DW/2 steps.
  function automatic int unsigned sqrt_iters(input int unsigned dw);
    return dw / 2;
  endfunction

endpackage

// File: rtl/sqrt_sequencer_if.sv
// Operand/result handshake bundle between a client and the square-root sequencer.
interface sqrt_sequencer_if #(
  parameter int unsigned DW = 16
);

  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_root;
  logic [DW-1:0] out_rem;
  logic          out_err;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_root, out_rem, out_err
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_root, out_rem, out_err
  );

endinterface

// File: rtl/sqrt_sequencer.sv
// Control FSM for the iterative non-restoring square-root datapath: accepts one
// operand, steps the datapath through clear/iterate/correct, and holds the result.
module sqrt_sequencer
  import sqrt_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic           clk,
  input  logic           reset,
  sqrt_sequencer_if.slave io,
  output logic           busy,
  output logic           dp_rst_n,
  output logic           dp_load,
  output logic           dp_ctrl,
  output logic [DW-1:0]  dp_d,
  output logic [DW-1:0]  dp_excounter,
  input  logic [DW-1:0]  dp_q,
  input  logic [DW-1:0]  dp_rem
);

  localparam int unsigned ITERS = sqrt_iters(DW);
  localparam int unsigned CW    = $clog2(ITERS);

  if ((DW < 4) || ((DW % 2) != 0)) begin : g_dw_check
    $error("sqrt_sequencer: DW must be even and at least 4");
  end

  sqrt_seq_state_e state_q, state_nx;
  logic [CW-1:0]   cnt_q, cnt_nx;
  logic            accept_c;
  logic            capture_c;
  logic            in_ready_nx;
  logic            out_valid_nx;
  logic            busy_nx;
  logic            dp_rst_n_nx;
  logic            dp_load_nx;
  logic            dp_ctrl_nx;

  // Next state, counter and control pins; every registered output is decoded
  // from the next state so the datapath pins come straight from flops.
  always_comb begin
    state_nx  = state_q;
    cnt_nx    = cnt_q;
    accept_c  = 1'b0;
    capture_c = 1'b0;

    case (state_q)
      IDLE: begin
        if (io.in_valid && io.in_ready) begin
          state_nx = CLEAR;
          accept_c = 1'b1;
          cnt_nx   = CW'(ITERS - 1);
        end
      end
      CLEAR: state_nx = ITER;
      ITER: begin
        if (cnt_q == '0) begin
          state_nx = CORR;
        end else begin
          cnt_nx = cnt_q - CW'(1);
        end
      end
      CORR: begin
        state_nx  = DONE;
        capture_c = 1'b1;
      end
      DONE: begin
        if (io.out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase

    // Abort wins over every handshake; captured results are left untouched.
    if (io.flush) begin
      state_nx  = IDLE;
      cnt_nx    = '0;
      accept_c  = 1'b0;
      capture_c = 1'b0;
    end

    in_ready_nx  = (state_nx == IDLE);
    busy_nx      = (state_nx != IDLE);
    out_valid_nx = (state_nx == DONE);
    dp_rst_n_nx  = (state_nx != CLEAR);
    dp_load_nx   = !((state_nx == ITER) || (state_nx == CORR));
    dp_ctrl_nx   = (state_nx == CORR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
      busy         <= 1'b0;
      io.out_root  <= '0;
      io.out_rem   <= '0;
      io.out_err   <= 1'b0;
      dp_rst_n     <= 1'b0;
      dp_load      <= 1'b1;
      dp_ctrl      <= 1'b0;
      dp_d         <= '0;
    end else begin
      state_q      <= state_nx;
      cnt_q        <= cnt_nx;
      io.in_ready  <= in_ready_nx;
      io.out_valid <= out_valid_nx;
      busy         <= busy_nx;
      dp_rst_n     <= dp_rst_n_nx;
      dp_load      <= dp_load_nx;
      dp_ctrl      <= dp_ctrl_nx;
      if (accept_c) begin
        dp_d <= io.in_data;
      end
      if (capture_c) begin
        io.out_root <= dp_q;
        io.out_rem  <= dp_rem;
        io.out_err  <= dp_rem[DW-1];
      end
    end
  end

  assign dp_excounter = DW'(cnt_q);

  // Result must stay put while the consumer stalls.
  a_hold_result: assert property (@(posedge clk) disable iff (!reset)
    (io.out_valid && !io.out_ready && !io.flush) |=>
      (io.out_valid && $stable(io.out_root) && $stable(io.out_rem) && $stable(io.out_err)));

  a_ready_idle: assert property (@(posedge clk) disable iff (!reset)
    io.in_ready |-> !busy);

  a_ctrl_last: assert property (@(posedge clk) disable iff (!reset)
    dp_ctrl |-> (!dp_load && (dp_excounter == '0)));

endmodule

// File: tb/tb_sqrt_sequencer.sv
// Randomized and directed self-checking bench for sqrt_sequencer with a behavioural datapath stub.
module tb_sqrt_sequencer;

  localparam int DW    = 16;
  localparam int ITERS = DW / 2;

  logic          clk;
  logic          reset;
  logic          busy;
  logic          dp_rst_n;
  logic          dp_load;
  logic          dp_ctrl;
  logic [DW-1:0] dp_d;
  logic [DW-1:0] dp_excounter;
  logic [DW-1:0] dp_q;
  logic [DW-1:0] dp_rem;
  bit            force_neg;

  int n_checks = 0;
  int n_fail   = 0;

  sqrt_sequencer_if #(.DW(DW)) io ();

  sqrt_sequencer #(.DW(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .io           (io.slave),
    .busy         (busy),
    .dp_rst_n     (dp_rst_n),
    .dp_load      (dp_load),
    .dp_ctrl      (dp_ctrl),
    .dp_d         (dp_d),
    .dp_excounter (dp_excounter),
    .dp_q         (dp_q),
    .dp_rem       (dp_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int unsigned isqrt(input int unsigned d);
    int unsigned r = 0;
    for (int unsigned i = 1; i <= 256; i++) begin
      if (i * i <= d) r = i;
    end
    return r;
  endfunction

  // Datapath stub: the final root/remainder only appear while the correction
  // step is driven; other cycles show junk so a mistimed capture is visible.
  always_comb begin
    int unsigned r;
    logic [DW-1:0] rem;
    r   = isqrt(32'(dp_d));
    rem = DW'(32'(dp_d) - r * r);
    if (force_neg) rem[DW-1] = 1'b1;
    if (dp_ctrl) begin
      dp_q   = DW'(r);
      dp_rem = rem;
    end else begin
      dp_q   = dp_excounter ^ 16'hA5C3;
      dp_rem = ~dp_d;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string p);
    check({p, "_in_ready"},  32'(io.in_ready), 1);
    check({p, "_out_valid"}, 32'(io.out_valid), 0);
    check({p, "_busy"},      32'(busy), 0);
    check({p, "_out_root"},  32'(io.out_root), 0);
    check({p, "_out_rem"},   32'(io.out_rem), 0);
    check({p, "_out_err"},   32'(io.out_err), 0);
    check({p, "_dp_rst_n"},  32'(dp_rst_n), 0);
    check({p, "_dp_load"},   32'(dp_load), 1);
    check({p, "_dp_ctrl"},   32'(dp_ctrl), 0);
    check({p, "_dp_d"},      32'(dp_d), 0);
    check({p, "_dp_exc"},    32'(dp_excounter), 0);
  endtask

  // Waits for IDLE, offers d, and returns just after the accept edge.
  task automatic start_op(input logic [DW-1:0] d);
    int n = 0;
    while (!io.in_ready && n < 40) begin
      step();
      n++;
    end
    check("ready_before_accept", 32'(io.in_ready), 1);
    io.in_valid = 1'b1;
    io.in_data  = d;
    step();
    io.in_valid = 1'b0;
    io.in_data  = DW'($urandom);
  endtask

  // From just after the accept edge: checks datapath sequencing, latency,
  // stall behaviour and the result against the reference model.
  task automatic finish_op(input logic [DW-1:0] d, input int stall);
    int k = 0;
    int proto_bad = 0;
    int clr_n = 0;
    int ctrl_n = 0;
    int rdy_n = 0;
    int hold_bad = 0;
    int unsigned er;
    logic [DW-1:0] exp_rem;
    logic [DW-1:0] snap_root;
    logic [DW-1:0] snap_rem;

    er      = isqrt(32'(d));
    exp_rem = DW'(32'(d) - er * er);
    if (force_neg) exp_rem[DW-1] = 1'b1;
    io.out_ready = (stall == 0);
    check("dp_d_latched", 32'(dp_d), 32'(d));

    while (!io.out_valid && k < 40) begin
      if (!dp_rst_n) clr_n++;
      if (dp_ctrl) ctrl_n++;
      if (io.in_ready || !busy) rdy_n++;
      if (k == 0 && !dp_load) proto_bad++;
      if (k >= 1 && k <= ITERS && (dp_load || dp_excounter != DW'(ITERS - k))) proto_bad++;
      if (k == ITERS + 1 && (dp_load || dp_excounter != '0)) proto_bad++;
      step();
      k++;
    end
    check("latency", 32'(k + 1), 32'(ITERS + 3));
    check("clear_cycles", 32'(clr_n), 1);
    check("ctrl_cycles", 32'(ctrl_n), 1);
    check("ready_while_busy", 32'(rdy_n), 0);
    check("dp_sequence", 32'(proto_bad), 0);

    snap_root = io.out_root;
    snap_rem  = io.out_rem;
    for (int i = 0; i < stall; i++) begin
      step();
      if (!io.out_valid || io.out_root !== snap_root || io.out_rem !== snap_rem || io.in_ready)
        hold_bad++;
    end
    check("stall_hold", 32'(hold_bad), 0);

    check("root", 32'(io.out_root), er);
    check("rem", 32'(io.out_rem), 32'(exp_rem));
    check("err", 32'(io.out_err), 32'(exp_rem[DW-1]));
    check("done_dp_load", 32'(dp_load), 1);
    io.out_ready = 1'b1;
    step();
    check("post_out_valid", 32'(io.out_valid), 0);
    check("post_in_ready", 32'(io.in_ready), 1);
    check("post_busy", 32'(busy), 0);
  endtask

  task automatic run_op(input logic [DW-1:0] d, input int stall);
    start_op(d);
    check("accept_busy", 32'(busy), 1);
    check("accept_in_ready", 32'(io.in_ready), 0);
    finish_op(d, stall);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_t[$];
    logic [DW-1:0] res_root[$];
    logic [DW-1:0] res_rem[$];
    int rdy_bad;
    int n;
    logic [DW-1:0] d;

    reset        = 1'b0;
    force_neg    = 1'b0;
    io.in_valid  = 1'b0;
    io.in_data   = '0;
    io.flush     = 1'b0;
    io.out_ready = 1'b1;
    repeat (3) step();
    check_reset_values("init");
    reset = 1'b1;
    step();
    check("init_dp_rst_n_release", 32'(dp_rst_n), 1);

    run_op(DW'(144), 0);
    check("root_144", 32'(io.out_root), 12);
    check("rem_144", 32'(io.out_rem), 0);
    check("err_144", 32'(io.out_err), 0);

    force_neg = 1'b1;
    run_op(DW'(144), 0);
    check("neg_err", 32'(io.out_err), 1);
    force_neg = 1'b0;

    // Back-to-back with in_valid held high throughout.
    rdy_bad = 0;
    io.in_valid = 1'b1;
    io.in_data  = DW'(200);
    for (int t = 0; t < 40 && res_root.size() < 2; t++) begin
      if (io.in_ready && busy) rdy_bad++;
      if (io.in_valid && io.in_ready) acc_t.push_back(t);
      if (io.out_valid && io.out_ready) begin
        res_root.push_back(io.out_root);
        res_rem.push_back(io.out_rem);
      end
      step();
      if (acc_t.size() == 1) io.in_data = '0;
      if (acc_t.size() == 2) io.in_valid = 1'b0;
    end
    io.in_valid = 1'b0;
    check("b2b_ready_low", 32'(rdy_bad), 0);
    check("b2b_accepts", 32'(acc_t.size()), 2);
    check("b2b_interval", (acc_t.size() == 2) ? 32'(acc_t[1] - acc_t[0]) : 32'hFFFF_FFFF, 32'(ITERS + 4));
    check("b2b_results", 32'(res_root.size()), 2);
    if (res_root.size() == 2) begin
      check("b2b_root0", 32'(res_root[0]), 14);
      check("b2b_rem0", 32'(res_rem[0]), 4);
      check("b2b_root1", 32'(res_root[1]), 0);
      check("b2b_rem1", 32'(res_rem[1]), 0);
    end

    run_op(DW'(65535), 20);
    check("root_65535", 32'(io.out_root), 255);
    check("rem_65535", 32'(io.out_rem), 510);

    // Asynchronous reset in the middle of the iteration phase.
    start_op(DW'($urandom_range(1, 65535)));
    n = 0;
    while (!(dp_excounter == DW'(3) && !dp_load) && n < 20) begin
      step();
      n++;
    end
    check("reach_exc3", 32'(dp_excounter), 3);
    reset = 1'b0;
    #1;
    check_reset_values("midreset");
    step();
    check("reset_low_dp_rst_n", 32'(dp_rst_n), 0);
    reset = 1'b1;
    step();
    check("reset_release_dp_rst_n", 32'(dp_rst_n), 1);
    run_op(DW'(49), 0);
    check("root_49", 32'(io.out_root), 7);
    check("rem_49", 32'(io.out_rem), 0);

    // Flush during iteration.
    start_op(DW'($urandom_range(0, 65535)));
    repeat (3) step();
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    check("flush_iter_valid", 32'(io.out_valid), 0);
    check("flush_iter_busy", 32'(busy), 0);
    check("flush_iter_ready", 32'(io.in_ready), 1);
    check("flush_iter_load", 32'(dp_load), 1);
    check("flush_iter_ctrl", 32'(dp_ctrl), 0);
    check("flush_iter_root_kept", 32'(io.out_root), 7);
    run_op(DW'(81), 0);
    check("root_81a", 32'(io.out_root), 9);

    // Flush while the result is waiting.
    d = DW'($urandom_range(0, 65535));
    io.out_ready = 1'b0;
    start_op(d);
    n = 0;
    while (!io.out_valid && n < 40) begin
      step();
      n++;
    end
    check("flush_done_reached", 32'(io.out_valid), 1);
    io.flush = 1'b1;
    step();
    io.flush = 1'b0;
    io.out_ready = 1'b1;
    check("flush_done_valid", 32'(io.out_valid), 0);
    check("flush_done_busy", 32'(busy), 0);
    check("flush_done_root_kept", 32'(io.out_root), isqrt(32'(d)));
    run_op(DW'(81), 0);
    check("root_81b", 32'(io.out_root), 9);
    check("rem_81b", 32'(io.out_rem), 0);

    // Flush coincident with an offered operand in IDLE.
    io.flush    = 1'b1;
    io.in_valid = 1'b1;
    io.in_data  = DW'(121);
    check("flush_idle_ready", 32'(io.in_ready), 1);
    step();
    io.flush = 1'b0;
    check("flush_idle_busy", 32'(busy), 0);
    check("flush_idle_ready_after", 32'(io.in_ready), 1);
    step();
    io.in_valid = 1'b0;
    check("flush_idle_accept_next", 32'(busy), 1);
    finish_op(DW'(121), 0);

    for (int i = 0; i < 12; i++) begin
      run_op(DW'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
